// File: rtl/fir_channel_arbiter.sv
`timescale 1ns/1ps
// fir_channel_arbiter: round-robin sharing of one FIR core between two sample channels.
// Optional watchdog on ISSUE/BUSY/RECOVER enabled by FIR_ARB_TIMEOUT_EN.
module fir_channel_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 31
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] sample0,
  input  logic [DATA_W-1:0] sample1,
  output logic [1:0]        ack,
  output logic              fir_dr,
  output logic [DATA_W-1:0] fir_sample,
  input  logic              fir_modwait,
  input  logic              fir_err,
  input  logic [DATA_W-1:0] fir_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              result_ch,
  output logic [1:0]        err_flag,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, ERR, RECOVER} state_t;
  state_t state, state_next;
  logic gch, last_grant, pick, tmo_hit, waiting;
  assign pick    = (req == 2'b11) ? ~last_grant : req[1];
  assign waiting = (state == ISSUE) || (state == BUSY) || (state == RECOVER);
  assign fir_dr       = (state == ISSUE) || (state == ERR);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  // an error seen while still issuing skips the ack, so the request stays pending
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = |req ? ISSUE : IDLE;
      ISSUE:   state_next = fir_err ? ERR : fir_modwait ? BUSY : ISSUE;
      BUSY:    state_next = fir_modwait ? BUSY : fir_err ? ERR : DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = RECOVER;
      RECOVER: state_next = (fir_err || fir_modwait) ? RECOVER : IDLE;
      default: state_next = IDLE;
    endcase
    if (tmo_hit) state_next = IDLE;
  end
`ifdef FIR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = waiting && (tmo == TW'(TMO_CYC - 1));
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) tmo <= '0;
    else tmo <= (waiting && state_next == state) ? tmo + TW'(1) : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state      <= IDLE;
      gch        <= 1'b0;
      last_grant <= 1'b1;
      fir_sample <= '0;
      ack        <= '0;
      result     <= '0;
      result_ch  <= 1'b0;
      err_flag   <= '0;
    end else begin
      state <= state_next;
      ack   <= (state == ISSUE && state_next == BUSY) ? (gch ? 2'b10 : 2'b01) : 2'b00;
      if (state == IDLE && |req) begin
        gch        <= pick;
        fir_sample <= pick ? sample1 : sample0;
      end
      if (state == ISSUE && state_next == BUSY) last_grant <= gch;
      if (state == BUSY && state_next == DONE) begin
        result        <= fir_result;
        result_ch     <= gch;
        err_flag[gch] <= 1'b0;
      end
      if (state_next == ERR || tmo_hit) err_flag[gch] <= 1'b1;
    end
endmodule

// File: tb/tb_fir_channel_arbiter.sv
`timescale 1ns/1ps
// tb_fir_channel_arbiter: vector table plus corner sequences against a behavioural FIR core.
module tb_fir_channel_arbiter;
  localparam int DW = 16;
  logic clk = 0, n_reset = 0;
  logic [1:0] req = '0;
  logic [DW-1:0] sample0 = '0, sample1 = '0;
  logic [1:0] ack, err_flag;
  logic fir_dr, fir_modwait, fir_err, result_valid, result_ch, busy;
  logic [DW-1:0] fir_sample, fir_result, result;
  int checks = 0, errors = 0;
  int dr_cnt = 0, ack_cnt = 0, rv_cnt = 0;
  int mw_len = 3, rsp_dly = 0;
  bit inj_err = 0, err_issue = 0, core_en = 1;
  bit ack_q[$];
  logic [DW:0] res_q[$];

  fir_channel_arbiter dut (
    .clk(clk), .n_reset(n_reset), .req(req), .sample0(sample0), .sample1(sample1),
    .ack(ack), .fir_dr(fir_dr), .fir_sample(fir_sample), .fir_modwait(fir_modwait),
    .fir_err(fir_err), .fir_result(fir_result), .result(result),
    .result_valid(result_valid), .result_ch(result_ch), .err_flag(err_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] core_f(input logic [DW-1:0] s);
    return s >> 1;
  endfunction

  // behavioural FIR core: modwait after dr, result on modwait fall, err cleared by a dr pulse
  initial begin
    logic [DW-1:0] smp;
    fir_modwait = 0; fir_err = 0; fir_result = '0;
    forever begin
      @(posedge clk); #1;
      if (!n_reset) begin
        fir_modwait = 0; fir_err = 0;
      end else if (fir_dr && core_en) begin
        if (err_issue) begin
          err_issue = 0; fir_err = 1;
          for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (fir_dr || !n_reset) break; end
          fir_err = 0;
        end else begin
          for (int k = 0; k < rsp_dly; k++) begin @(posedge clk); #1; end
          smp = fir_sample; fir_modwait = 1;
          for (int k = 0; k < mw_len && n_reset; k++) begin @(posedge clk); #1; end
          fir_modwait = 0;
          if (n_reset) begin
            fir_result = core_f(smp); fir_err = inj_err;
            if (inj_err) begin
              for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (fir_dr || !n_reset) break; end
              fir_err = 0;
            end
          end
        end
      end
    end
  end

  // scoreboard: every ack and result pulse must match the head of its queue
  always @(negedge clk) begin
    if (fir_dr) dr_cnt++;
    if (|ack) begin
      ack_cnt++;
      if (ack_q.size() == 0) check("ack_unexpected", ack, 0);
      else check("ack", ack, ack_q.pop_front() ? 2'b10 : 2'b01);
    end
    if (result_valid) begin
      rv_cnt++;
      if (res_q.size() == 0) check("result_unexpected", result_valid, 0);
      else check("result", {result_ch, result}, res_q.pop_front());
    end
  end

  task automatic wait_busy(input logic val, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (busy === val) break;
    end
    check("wait_busy", busy, val);
  endtask

  task automatic wait_ack(input int a0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack_cnt != a0) break;
    end
    check("ack_seen", ack_cnt - a0, 1);
  endtask

  task automatic check_reset_outputs;
    check("rst_ack", ack, 0);
    check("rst_dr", fir_dr, 0);
    check("rst_sample", fir_sample, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_ch", result_ch, 0);
    check("rst_ef", err_flag, 0);
    check("rst_busy", busy, 0);
  endtask

  typedef struct {
    logic [1:0] req; logic [DW-1:0] s0, s1; int mw; bit err;
    bit ch; logic [DW-1:0] res; logic [1:0] ef;
  } vec_t;
  vec_t v[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, r0;
    v[0] = '{2'b01, 16'h0100, 16'h0000, 14, 0, 0, 16'h0080, 2'b00};
    v[1] = '{2'b11, 16'h1234, 16'h4000, 3, 0, 1, 16'h2000, 2'b00};
    v[2] = '{2'b11, 16'h1234, 16'h4000, 3, 0, 0, 16'h091A, 2'b00};
    v[3] = '{2'b11, 16'h1234, 16'h4000, 3, 0, 1, 16'h2000, 2'b00};
    v[4] = '{2'b11, 16'h1234, 16'h4000, 3, 0, 0, 16'h091A, 2'b00};
    v[5] = '{2'b10, 16'h0000, 16'h0AAA, 5, 1, 1, 16'h0000, 2'b10};
    v[6] = '{2'b10, 16'h0000, 16'h0BBB, 4, 0, 1, 16'h05DD, 2'b00};
    v[7] = '{2'b01, 16'h0C0C, 16'h0000, 2, 1, 0, 16'h0000, 2'b01};
    v[8] = '{2'b10, 16'h0000, 16'h7FFE, 6, 0, 1, 16'h3FFF, 2'b01};
    v[9] = '{2'b01, 16'h0F00, 16'h0000, 1, 0, 0, 16'h0780, 2'b00};
    #12;
    check_reset_outputs();
    @(negedge clk); n_reset = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sample0 = v[i].s0; sample1 = v[i].s1; req = v[i].req;
      mw_len = v[i].mw; inj_err = v[i].err;
      ack_q.push_back(v[i].ch);
      if (!v[i].err) res_q.push_back({v[i].ch, v[i].res});
      d0 = dr_cnt;
      wait_busy(1, 10);
      wait_busy(0, 200);
      check($sformatf("vec%0d_err_flag", i), err_flag, v[i].ef);
      check($sformatf("vec%0d_dr_cycles", i), dr_cnt - d0, v[i].err ? 2 : 1);
    end
    req = 0; inj_err = 0;
    // requester drops req[0] while ISSUE is still waiting for the core
    sample0 = 16'h0222; rsp_dly = 3; mw_len = 2; req = 2'b01;
    ack_q.push_back(0); res_q.push_back({1'b0, 16'h0111});
    a0 = ack_cnt; r0 = rv_cnt;
    wait_busy(1, 10);
    req = 0;
    wait_busy(0, 100);
    check("drop_ack", ack_cnt - a0, 1);
    check("drop_rv", rv_cnt - r0, 1);
    rsp_dly = 0;
    // core error during ISSUE: no ack, flag set, request retried
    sample0 = 16'h0444; err_issue = 1; req = 2'b01;
    ack_q.push_back(0); res_q.push_back({1'b0, 16'h0222});
    a0 = ack_cnt; r0 = rv_cnt; d0 = dr_cnt;
    wait_busy(1, 10);
    wait_busy(0, 50);
    check("issue_err_flag", err_flag, 2'b01);
    check("issue_err_noack", ack_cnt - a0, 0);
    check("issue_err_dr", dr_cnt - d0, 2);
    wait_busy(1, 10);
    req = 0;
    wait_busy(0, 50);
    check("retry_ack", ack_cnt - a0, 1);
    check("retry_rv", rv_cnt - r0, 1);
    check("retry_err_flag", err_flag, 2'b00);
    // reset in the middle of BUSY
    sample0 = 16'h0600; mw_len = 20; req = 2'b01;
    ack_q.push_back(0);
    a0 = ack_cnt; r0 = rv_cnt;
    wait_ack(a0);
    repeat (3) @(negedge clk);
    n_reset = 0; req = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    mw_len = 3; sample0 = 16'h0700; sample1 = 16'h0900; req = 2'b11; n_reset = 1;
    ack_q.push_back(0); res_q.push_back({1'b0, 16'h0380});
    wait_busy(1, 10);
    req = 0;
    wait_busy(0, 50);
    check("post_rst_rv", rv_cnt - r0, 1);
    n_reset = 0;
    @(negedge clk);
    n_reset = 1; req = 2'b10;
    ack_q.push_back(1); res_q.push_back({1'b1, 16'h0480});
    wait_busy(1, 10);
    req = 0;
    wait_busy(0, 50);
    check("post_rst2_rv", rv_cnt - r0, 2);
`ifdef FIR_ARB_TIMEOUT_EN
    // core never answers: watchdog must abort the transaction
    core_en = 0; req = 2'b01; sample0 = 16'h0123;
    d0 = dr_cnt; a0 = ack_cnt;
    wait_busy(1, 10);
    wait_busy(0, 100);
    req = 0;
    check("tmo_dr_cycles", dr_cnt - d0, 31);
    check("tmo_err_flag", err_flag, 2'b01);
    check("tmo_noack", ack_cnt - a0, 0);
    core_en = 1;
`endif
    repeat (3) @(negedge clk);
    check("ack_q_empty", ack_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
